// File: rtl/exp_datapath.sv
// exp_datapath
// Iterative fixed-point datapath for the 6-term Taylor series of e^x.
// x is unsigned Q0.16, the running term T and sum S are unsigned Q2.16.
// Each enabled cycle multiplies the current term by x and by the next
// Taylor coefficient 1/(k+1). The product is added into the sum, so after
// five enabled cycles S = 1 + x + x^2/2 + x^3/6 + x^4/24 + x^5/120.
// The start/ready/done controller above this block drives clr, c_en and
// reg_en, and it watches c5 to learn that the iteration is complete.

module exp_datapath #(
  parameter int XW = 16,
  parameter int RW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          c_en,
  input  logic          reg_en,
  input  logic [XW-1:0] x_in,
  output logic          c5,
  output logic [RW-1:0] result
);

  // Coefficients are Q1.16, one bit wider than x, so that 1.0 fits.
  localparam int CW = XW + 1;
  // Width of the T * x product.
  localparam int PW = RW + XW;
  // Width of the P1 * C product.
  localparam int TW = RW + CW;

  localparam logic [RW-1:0] ONE_Q    = 18'h10000;
  localparam logic [2:0]    CNT_LAST = 3'd5;
  localparam logic [2:0]    CNT_ZERO = 3'd0;
  localparam logic [2:0]    CNT_STEP = 3'd1;

  // Taylor coefficient 1/(idx+1) in Q1.16. Each value is truncated.
  // Indices past the last term return zero, but the iteration never
  // reads them because the counter saturates at 5.
  function automatic logic [CW-1:0] coef_rom(input logic [2:0] idx);
    logic [CW-1:0] c;
    case (idx)
      3'd0:    c = 17'h10000;
      3'd1:    c = 17'h08000;
      3'd2:    c = 17'h05555;
      3'd3:    c = 17'h04000;
      3'd4:    c = 17'h03333;
      default: c = 17'h00000;
    endcase
    return c;
  endfunction

  // Architectural state
  logic [XW-1:0] r_x;
  logic [RW-1:0] r_t;
  logic [RW-1:0] r_s;
  logic [2:0]    r_cnt;

  // Datapath wires
  logic          w_active;
  logic [CW-1:0] w_coef;
  logic [PW-1:0] w_p1_full;
  logic [RW-1:0] w_p1;
  logic [TW-1:0] w_tn_full;
  logic [RW-1:0] w_tn;
  logic [RW-1:0] w_sum;

  // While the counter is below 5, both the term path and the counter may advance.
  assign w_active = (r_cnt < CNT_LAST);

  // The coefficient is looked up with the counter value from before this edge.
  assign w_coef = coef_rom(r_cnt);

  // P1 = T * x, truncated back to Q2.16. Because T <= 1.0 and x < 1.0,
  // the bits above the kept field are always zero.
  assign w_p1_full = PW'(r_t) * PW'(r_x);
  assign w_p1      = RW'(w_p1_full >> XW);

  // Tn = P1 * C, truncated back to Q2.16. Again the dropped high bits are zero.
  assign w_tn_full = TW'(w_p1) * TW'(w_coef);
  assign w_tn      = RW'(w_tn_full >> XW);

  // S stays below e < 4, so this sum never overflows Q2.16.
  assign w_sum = r_s + w_tn;

  // Operand, term and sum registers. Async reset has top priority, then the
  // controller's clear (which loads x and 1.0), then the enabled term update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= '0;
      r_t <= '0;
      r_s <= '0;
    end else if (clr) begin
      r_x <= x_in;
      r_t <= ONE_Q;
      r_s <= ONE_Q;
    end else if (reg_en && w_active) begin
      r_t <= w_tn;
      r_s <= w_sum;
    end else begin
      r_x <= r_x;
      r_t <= r_t;
      r_s <= r_s;
    end
  end

  // Iteration counter. It is enabled separately from the term registers and
  // saturates at 5 instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= CNT_ZERO;
    end else if (clr) begin
      r_cnt <= CNT_ZERO;
    end else if (c_en && w_active) begin
      r_cnt <= r_cnt + CNT_STEP;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // c5 is decoded directly from the counter register. It rises on the same
  // edge that writes the final sum, so the controller sees both together.
  assign c5     = (r_cnt == CNT_LAST);
  assign result = r_s;

endmodule

// File: tb/tb_exp_datapath.sv
// Self-checking bench for exp_datapath: directed scenarios followed by
// randomized control and operand traffic, compared against a plain
// arithmetic model of the Taylor iteration.

module tb_exp_datapath;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        c_en;
  logic        reg_en;
  logic [15:0] x_in;
  logic        c5;
  logic [17:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, in plain integers
  longint unsigned m_x, m_t, m_s;
  int              m_cnt;
  longint unsigned coef [0:4] = '{65536, 32768, 21845, 16384, 13107};

  exp_datapath dut (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .c_en   (c_en),
    .reg_en (reg_en),
    .x_in   (x_in),
    .c5     (c5),
    .result (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if the values differ.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_t = 0; m_s = 0; m_cnt = 0;
  endtask

  // Advances the model by one clock edge. Term k+1 is
  // floor(floor(T*x / 2^16) * (1/(k+1) in Q1.16) / 2^16).
  task automatic model_edge(input bit cl, input bit ce, input bit re, input int unsigned x);
    longint unsigned p1, tn;
    if (cl) begin
      m_x = x; m_t = 65536; m_s = 65536; m_cnt = 0;
    end else begin
      if (re && m_cnt < 5) begin
        p1  = (m_t * m_x) / 65536;
        tn  = (p1 * coef[m_cnt]) / 65536;
        m_t = tn;
        m_s = m_s + tn;
      end
      if (ce && m_cnt < 5) m_cnt = m_cnt + 1;
    end
  endtask

  // Drives one cycle of inputs, steps the model on the edge and settles 1 time unit past the edge.
  task automatic step(input bit cl, input bit ce, input bit re, input logic [15:0] x);
    clr = cl; c_en = ce; reg_en = re; x_in = x;
    @(posedge clk);
    model_edge(cl, ce, re, x);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_res"}, {14'd0, result}, m_s[31:0]);
    check({tag, "_c5"},  {31'd0, c5},     (m_cnt == 5) ? 32'd1 : 32'd0);
  endtask

  logic [17:0] exp_seq [0:4] = '{18'h18000, 18'h1A000, 18'h1A555, 18'h1A5FF, 18'h1A60F};

  initial begin
    rst = 1'b1; clr = 1'b0; c_en = 1'b0; reg_en = 1'b0; x_in = 16'h0;
    model_reset();
    @(posedge clk); #1;
    check("rst_res", {14'd0, result}, 32'h0);
    check("rst_c5",  {31'd0, c5}, 32'h0);
    @(negedge clk); rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 16'h0);
    check("post_rst_res", {14'd0, result}, 32'h0);
    check("post_rst_c5",  {31'd0, c5}, 32'h0);

    // Nominal run with x = 0.5
    step(1'b1, 1'b0, 1'b0, 16'h8000);
    check("load_res", {14'd0, result}, 32'h10000);
    check("load_c5",  {31'd0, c5}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1, 16'h0);
      check("half_seq", {14'd0, result}, {14'd0, exp_seq[i]});
      check("half_c5",  {31'd0, c5}, (i == 4) ? 32'd1 : 32'd0);
    end
    // Extra enables after completion leave everything as it is.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 16'h0);
      check("sat_res", {14'd0, result}, 32'h1A60F);
      check("sat_c5",  {31'd0, c5}, 32'h1);
    end

    // x = 0: the result stays at 1.0.
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1, 16'h0);
      check("zero_res", {14'd0, result}, 32'h10000);
      check("zero_c5",  {31'd0, c5}, (i == 4) ? 32'd1 : 32'd0);
    end

    // A clear in the middle of a run takes priority over the enables.
    step(1'b1, 1'b0, 1'b0, 16'h8000);
    step(1'b0, 1'b1, 1'b1, 16'h0);
    step(1'b0, 1'b1, 1'b1, 16'h0);
    step(1'b1, 1'b1, 1'b1, 16'h4000);
    check("midclr_res", {14'd0, result}, 32'h10000);
    check("midclr_c5",  {31'd0, c5}, 32'h0);
    step(1'b0, 1'b1, 1'b1, 16'h0);
    check("midclr_next", {14'd0, result}, 32'h14000);

    // reg_en alone reuses index 0; c_en alone skips a term.
    step(1'b1, 1'b0, 1'b0, 16'h8000);
    step(1'b0, 1'b0, 1'b1, 16'h0);
    check("regonly1", {14'd0, result}, 32'h18000);
    step(1'b0, 1'b0, 1'b1, 16'h0);
    check("regonly2", {14'd0, result}, 32'h1C000);
    check("regonly_c5", {31'd0, c5}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check("cenonly", {14'd0, result}, 32'h1C000);
    step(1'b0, 1'b1, 1'b1, 16'h0);
    check("after_skip", {14'd0, result}, 32'h1D000);

    // Async reset mid-iteration clears the outputs with no clock edge.
    step(1'b1, 1'b0, 1'b0, 16'h8000);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h8000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 16'h0);
    clr = 1'b0; c_en = 1'b0; reg_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_res", {14'd0, result}, 32'h0);
    check("async_c5",  {31'd0, c5}, 32'h0);
    #1 rst = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 1'b0, 16'h0);
    check_model("after_async");

    // Randomized traffic compared against the model
    step(1'b1, 1'b0, 1'b0, 16'($urandom));
    check_model("rnd_load");
    for (int i = 0; i < 600; i++) begin
      logic cl, ce, re;
      logic [15:0] xv;
      cl = ($urandom_range(0, 7) == 0);
      ce = ($urandom_range(0, 3) != 0);
      re = ($urandom_range(0, 3) != 0);
      xv = 16'($urandom);
      step(cl, ce, re, xv);
      check_model("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exp_datapath.md
Name: exp_datapath

Overview:
- Iterative fixed-point datapath computing the 6-term Taylor approximation e^x ≈ 1 + x + x²/2 + x³/6 + x⁴/24 + x⁵/120 for an unsigned fractional operand.
- Sits directly under the start/ready/done control FSM. It consumes that FSM's reset (sync clear), c_en and reg_en strobes, and returns the c5 iteration-complete flag.
- One term is produced per enabled cycle. Five enabled cycles finish the result.

Parameters:
- XW, 16, operand width; x is unsigned Q0.XW.
- RW, 18, term/sum width; unsigned Q2.16 (RW = XW + 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear/load; driven by the controller's reset output.
- c_en  input  1  iteration counter enable.
- reg_en  input  1  term/sum register enable.
- x_in  input  XW  operand, Q0.16.
- c5  output  1  high when iteration count == 5.
- result  output  RW  running sum S, Q2.16.

Behaviour:
- State: x_reg[15:0], T[17:0] (current term), S[17:0] (sum), cnt[2:0].
- Async rst (highest priority): x_reg=0, T=0, S=0, cnt=0. So result=0 and c5=0 while rst is held and after release until the first clr.
- clr (priority over c_en/reg_en), on the clock edge:
  - x_reg<=x_in; T<=0x10000 (1.0); S<=0x10000; cnt<=0.
  - While clr stays high, x is re-captured every cycle. The last clr cycle's x_in is used.
- Coefficient ROM, 17-bit Q1.16, indexed by cnt: 0→0x10000, 1→0x8000, 2→0x5555, 3→0x4000, 4→0x3333; 5–7→0.
- reg_en=1 with clr=0 and cnt<5:
  - P1 = (T*x_reg)[33:16], truncating.
  - Tn = (P1*C[cnt])[33:16], truncating.
  - T<=Tn; S<=S+Tn.
  - Uses cnt as it stood before this edge.
- reg_en=1 with cnt==5: T and S hold.
- c_en=1 with clr=0 and cnt<5: cnt<=cnt+1. At cnt==5 it saturates and holds; no wrap.
- c_en and reg_en act independently:
  - reg_en without c_en repeats the same coefficient index.
  - c_en without reg_en skips a term.
  - The controller always asserts both together; the bench checks the independent cases anyway.
- c5 = (cnt==5), combinational from the register. It rises in the same cycle S holds the final value.
- Nominal sequence: controller state A (start fallen) gives 1 enabled cycle, then state B gives 4 more. c5 rises after the 5th enabled edge. Total latency is 5 clocks from the first c_en/reg_en to final result.
- result = S, registered; stable while the controller sits in done state C.
- Width/overflow: T ≤ 1.0 and S < e < 4 for all x < 1. No saturation logic; intermediate products are 34/35 bits and upper bits above [33] are provably zero.
- clr arriving mid-iteration (restart from C or A): reloads immediately. Partial results are discarded.
- rst asserted mid-iteration: all state clears asynchronously. A clr is required before the next computation.

Test Plan:
- rst pulse, then clr with x_in=0x8000, then 5 cycles c_en=reg_en=1 -> S sequence 0x18000, 0x1A000, 0x1A555, 0x1A5FF, 0x1A60F; c5=1 only after the 5th edge; result=0x1A60F.
- clr with x_in=0x0000, then 5 enabled cycles -> result stays 0x10000 throughout; c5=1 after the 5th edge.
- After completion (cnt=5), hold c_en=reg_en=1 for 3 more cycles -> cnt stays 5, c5 stays 1, result unchanged 0x1A60F.
- x=0x8000, enabled cycles 1–2, then assert clr with x_in=0x4000 together with c_en/reg_en -> cnt=0, T=S=0x10000, x_reg=0x4000 (clr wins). Next enabled edge gives S=0x14000.
- x=0x8000, one cycle reg_en=1 with c_en=0 -> S=0x18000, cnt=0. Next reg_en cycle (c_en=0) gives T=0x4000, S=0x1C000 (same index reused).
- Assert rst asynchronously between clock edges at cnt=3 -> result=0 and c5=0 immediately, with no clock edge needed.
